hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 16-bit, 8-register, 5-stage core.
//  Drives the hold/bubble/flush controls of IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Drives EX-stage forwarding selects.
//  Freezes the pipe while data memory is busy, with a timeout trap.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MAX_WAIT  15  memory-wait cycles (wait_cnt value) at which ERROR is entered
//  CNT_W     16  width of stall_cnt
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active high
//  id_rs,id_rt   in   3      source registers of the instruction in ID
//  id_uses_rt    in   1      ID instruction reads rt
//  ex_rs,ex_rt   in   3      source registers of the instruction in EX
//  ex_rd         in   3      destination register in EX
//  ex_wb,ex_load in   1      EX instruction writes back / is a load
//  mem_rd        in   3      EX/MEM rd_out
//  mem_wb        in   1      EX/MEM WB_out
//  mem_load      in   1      EX/MEM load_out
//  mem_wmem      in   1      EX/MEM WMEM_out
//  wb_rd         in   3      MEM/WB destination register
//  wb_wb         in   1      MEM/WB write-back enable
//  branch_taken  in   1      branch resolved taken in EX
//  mem_ready     in   1      data memory completes access this cycle
//  pc_en, ifid_en, idex_en, exmem_en  out 1  stage register load enables
//  ifid_flush    out  1      load NOP into IF/ID
//  idex_bubble   out  1      load NOP (all controls 0) into ID/EX
//  memwb_bubble  out  1      load NOP into MEM/WB
//  fwd_a,fwd_b   out  2      EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB
//  err           out  1      memory timeout trap
//  stall_cnt     out  CNT_W  cycles with pc_en=0, saturating
// BEHAVIOUR
//  State register: RUN, MEMWAIT, ERROR. wait_cnt is 4 bits. Control outputs are
//  Mealy: combinational from state and inputs. State, wait_cnt and stall_cnt are registered.
//  Reset: state=RUN, wait_cnt=0, stall_cnt=0, err=0.
//  Reset wins over every event, including mid-MEMWAIT and ERROR.
//  Register 0 is hardwired zero. rd==0 never matches for hazard or forwarding.
//  Default (no event): all enables=1; flush=bubble=0.
//  mem_req = mem_load|mem_wmem.
//  Event priority: ERROR > memory freeze > branch > load-use.
//  RUN, mem_req & !mem_ready -> freeze:
//   - pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1.
//   - Next state MEMWAIT, wait_cnt<=1.
//  RUN, mem_req & mem_ready -> no freeze (single-cycle access).
//  MEMWAIT, !mem_ready -> freeze continues.
//   - wait_cnt<=wait_cnt+1.
//   - When wait_cnt==MAX_WAIT -> ERROR.
//  MEMWAIT, mem_ready -> default enables this cycle, memwb_bubble=0; next state RUN.
//   - A branch or load-use present in this cycle is acted on, same as in RUN.
//  ERROR: full freeze, memwb_bubble=1, err=1 until rst.
//  Branch (branch_taken, not frozen):
//   - ifid_flush=1, idex_bubble=1, pc_en=1 (PC takes target). 2-cycle penalty.
//  Load-use (ex_load & ex_wb & ex_rd!=0 & (ex_rd==id_rs | id_uses_rt & ex_rd==id_rt)):
//   - pc_en=0, ifid_en=0, idex_bubble=1 for exactly one cycle.
//   - Suppressed by branch: the flush removes the dependent instruction.
//  Forwarding fwd_a for ex_rs (fwd_b identical with ex_rt):
//   - 01 if mem_wb & !mem_load & mem_rd==ex_rs & mem_rd!=0.
//   - else 10 if wb_wb & wb_rd==ex_rs & wb_rd!=0.
//   - else 00. EX/MEM has priority over MEM/WB.
//   - A load in EX/MEM never forwards; load-use guarantees it has reached MEM/WB.
//   - Forward selects stay valid while frozen.
//  stall_cnt increments every cycle pc_en=0 and saturates at all-ones.
// TESTING
//  1. ADD r1 in EX/MEM, EX reads rs=r1 -> fwd_a=01. Also wb_rd=r1 -> still 01.
//  2. LW r2 in EX, ID reads rt=r2, id_uses_rt=1 -> one cycle pc_en=0, idex_bubble=1.
//     Next cycle fwd_b=10.
//  3. branch_taken=1 coincident with load-use -> ifid_flush=1, idex_bubble=1, pc_en=1.
//     stall_cnt unchanged.
//  4. mem_load=1, mem_ready low 3 cycles -> 3 frozen cycles then release.
//     stall_cnt+=3; memwb_bubble=1 for those 3 cycles.
//  5. mem_ready held low -> ERROR after MAX_WAIT=15 frozen cycles, err=1.
//     rst -> RUN, err=0, stall_cnt=0.
//  6. Writes to r0 (ex_rd=0 load, mem_rd=0) -> no stall, fwd=00.
//     Saturation: force 65535 stalls -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: stage enables, NOP injection,
// EX forwarding selects, data-memory wait freeze with timeout trap, stall counter.
module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       ex_rs,
    input  logic [2:0]       ex_rt,
    input  logic [2:0]       ex_rd,
    input  logic             ex_wb,
    input  logic             ex_load,
    input  logic [2:0]       mem_rd,
    input  logic             mem_wb,
    input  logic             mem_load,
    input  logic             mem_wmem,
    input  logic [2:0]       wb_rd,
    input  logic             wb_wb,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

    state_t     state, state_nx;
    logic [3:0] wait_cnt, wait_nx;
    logic       mem_req, mem_frz, load_use;

    assign mem_req  = mem_load | mem_wmem;
    assign mem_frz  = ((state == RUN) && mem_req && !mem_ready) ||
                      ((state == MEMWAIT) && !mem_ready);
    assign load_use = ex_load && ex_wb && (ex_rd != 3'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 4'd0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // The trap fires on the cycle whose increment would bring wait_cnt to
    // MAX_WAIT, so exactly MAX_WAIT frozen cycles precede ERROR.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nx = MEMWAIT;
                    wait_nx  = 4'd1;
                end
            end
            MEMWAIT: begin
                if (mem_ready) begin
                    state_nx = RUN;
                    wait_nx  = 4'd0;
                end else if (wait_cnt >= 4'(MAX_WAIT - 1)) begin
                    state_nx = ERROR;
                    wait_nx  = 4'(MAX_WAIT);
                end else begin
                    wait_nx = wait_cnt + 4'd1;
                end
            end
            default: state_nx = ERROR;
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        err          = 1'b0;
        if (state == ERROR || mem_frz) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            err          = (state == ERROR);
        end else if (branch_taken) begin
            // Flushing the dependent instruction makes any load-use stall moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [2:0] src);
        if (mem_wb && !mem_load && (mem_rd == src) && (mem_rd != 3'd0))
            return 2'b01;
        else if (wb_wb && (wb_rd == src) && (wb_rd != 3'd0))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs);
        fwd_b = fwd_sel(ex_rt);
    end

endmodule
